// File: rtl/mc_table_loader_pkg.sv
// Shared definitions for the Monte-Carlo table loader: default geometry and
// the loader FSM state encoding.
package mc_table_loader_pkg;

  localparam int defaultT         = 512;
  localparam int defaultLogT      = 9;
  localparam int defaultPathWidth = 10;
  localparam int dataW            = 18;
  localparam int defaultAccW      = dataW + defaultLogT;
  localparam int checksumW        = 24;

  typedef enum logic [2:0] {
    LOAD_SIGMA = 3'd0,
    LOAD_MU    = 3'd1,
    WAIT_SWAP  = 3'd2,
    SWAP       = 3'd3,
    START      = 3'd4
  } loaderState_t;

endpackage

// File: rtl/mc_table_loader_result_slot.sv
// Result slot: one-entry valid/ready holding register for the core
// accumulator. A capture fills the slot; a handshake empties it.
module mc_table_loader_result_slot
  import mc_table_loader_pkg::*;
#(
  parameter int ACC_W = defaultAccW
) (
  input  logic             CLK,
  input  logic             iRstN,
  input  logic             iCapture,
  input  logic [ACC_W-1:0] iData,
  output logic [ACC_W-1:0] oData,
  output logic             oValid,
  input  logic             iReady
);

  // Fill on capture, drain one cycle after a valid/ready handshake.
  always_ff @(posedge CLK or negedge iRstN) begin
    if (!iRstN) begin
      oData  <= '0;
      oValid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks, so every flop
      // samples the values present before the edge regardless of order.
      if (iCapture) begin
        oData  <= iData;
        oValid <= 1'b1;
      end else if (oValid && iReady) begin
        oValid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mc_table_loader.sv
// Host-side table writer and sequencer for one Monte-Carlo core.
// Writes the exp-sigma table then the mu table into the core's write bank,
// hands the bank over with oSwitch, pulses oStart, and returns the core's
// accumulator through a one-entry result slot. Loading of the next batch
// overlaps the core's run of the current one.
// Optional feature: define MC_TABLE_LOADER_CHECKSUM_EN to get a per-batch
// 24-bit modular word sum on oChecksum; otherwise oChecksum is tied to 0.
module mc_table_loader
  import mc_table_loader_pkg::*;
#(
  parameter int T         = defaultT,
  parameter int logT      = defaultLogT,
  parameter int pathWidth = defaultPathWidth,
  parameter int ACC_W     = dataW + logT
) (
  input  logic                 CLK,
  input  logic                 iRstN,
  input  logic [dataW-1:0]     iData,
  input  logic                 iValid,
  output logic                 oReady,
  output logic [pathWidth-1:0] oSigmaWriteAddress,
  output logic [dataW-1:0]     oSigmaWriteData,
  output logic                 oSigmaWE,
  output logic [logT-1:0]      oMuWriteAddress,
  output logic [dataW-1:0]     oMuWriteData,
  output logic                 oMuWE,
  output logic                 oSwitch,
  output logic                 oStart,
  input  logic [ACC_W-1:0]     iCoreAcc,
  input  logic                 iCoreDone,
  output logic [ACC_W-1:0]     oResult,
  output logic                 oResultValid,
  input  logic                 iResultReady,
  output logic [checksumW-1:0] oChecksum
);

  localparam logic [pathWidth-1:0] sigmaLast = '1;
  localparam logic [logT-1:0]      muLast    = logT'(T - 1);

  loaderState_t         state;
  logic [pathWidth-1:0] sigmaCnt;
  logic [logT-1:0]      muCnt;
  logic                 coreBusy;
  logic                 doneQ;

  logic accept;
  logic doneRise;
  logic capture;
  logic swapGo;

  // Only the two load states take words; everything else back-pressures.
  assign oReady   = (state == LOAD_SIGMA) || (state == LOAD_MU);
  assign accept   = iValid && oReady;
  assign doneRise = iCoreDone && !doneQ;
  // A done edge only means something while a batch is actually running.
  assign capture  = doneRise && coreBusy;
  // Hand over the bank only once the core is idle and its result is drained.
  assign swapGo   = (state == WAIT_SWAP) && !coreBusy && !oResultValid && !capture;

  // Sequencer: table writes, bank handover, start pulse and core-busy tracking.
  always_ff @(posedge CLK or negedge iRstN) begin
    if (!iRstN) begin
      state              <= LOAD_SIGMA;
      sigmaCnt           <= '0;
      muCnt              <= '0;
      coreBusy           <= 1'b0;
      doneQ              <= 1'b0;
      oSigmaWriteAddress <= '0;
      oSigmaWriteData    <= '0;
      oSigmaWE           <= 1'b0;
      oMuWriteAddress    <= '0;
      oMuWriteData       <= '0;
      oMuWE              <= 1'b0;
      oSwitch            <= 1'b0;
      oStart             <= 1'b0;
    end else begin
      // NOTE: strobes get a default here so they fall unless a branch below
      // re-asserts them; every branch is then free to assign only what it owns.
      oSigmaWE <= 1'b0;
      oMuWE    <= 1'b0;
      oStart   <= 1'b0;
      doneQ    <= iCoreDone;

      if (capture) begin
        coreBusy <= 1'b0;
      end

      case (state)
        LOAD_SIGMA: begin
          if (accept) begin
            oSigmaWE           <= 1'b1;
            oSigmaWriteAddress <= sigmaCnt;
            oSigmaWriteData    <= iData;
            // Power-of-two depth: the increment wraps to 0 on its own.
            sigmaCnt           <= sigmaCnt + pathWidth'(1);
            if (sigmaCnt == sigmaLast) begin
              state <= LOAD_MU;
            end
          end
        end
        LOAD_MU: begin
          if (accept) begin
            oMuWE           <= 1'b1;
            oMuWriteAddress <= muCnt;
            oMuWriteData    <= iData;
            if (muCnt == muLast) begin
              muCnt <= '0;
              state <= WAIT_SWAP;
            end else begin
              muCnt <= muCnt + logT'(1);
            end
          end
        end
        WAIT_SWAP: begin
          if (swapGo) begin
            oSwitch <= ~oSwitch;
            state   <= SWAP;
          end
        end
        SWAP: begin
          oStart   <= 1'b1;
          coreBusy <= 1'b1;
          state    <= START;
        end
        START: begin
          state <= LOAD_SIGMA;
        end
        default: begin
          state <= LOAD_SIGMA;
        end
      endcase
    end
  end

  mc_table_loader_result_slot #(
    .ACC_W (ACC_W)
  ) resultSlot (
    .CLK      (CLK),
    .iRstN    (iRstN),
    .iCapture (capture),
    .iData    (iCoreAcc),
    .oData    (oResult),
    .oValid   (oResultValid),
    .iReady   (iResultReady)
  );

`ifdef MC_TABLE_LOADER_CHECKSUM_EN
  logic [checksumW-1:0] runSum;

  // Running modular sum of the batch; published and cleared at handover.
  always_ff @(posedge CLK or negedge iRstN) begin
    if (!iRstN) begin
      runSum    <= '0;
      oChecksum <= '0;
    end else if (swapGo) begin
      oChecksum <= runSum;
      runSum    <= '0;
    end else if (accept) begin
      runSum <= runSum + checksumW'(iData);
    end
  end
`else
  assign oChecksum = '0;
`endif

endmodule

// File: tb/tb_mc_table_loader.sv
// Self-checking bench for mc_table_loader. Words are driven with random
// valid gaps and random data; a scoreboard derived from the stream order
// (word k of a batch -> sigma[k] or mu[k-1024]) checks every table write,
// and scenario tasks check bank handover, start pulse and result slot.
module tb_mc_table_loader;

  localparam int nSigma = 1024;
  localparam int nMu    = 512;
  localparam int nBatch = nSigma + nMu;

  typedef struct {
    bit          isSigma;
    int          addr;
    logic [17:0] data;
    longint      stamp;
  } wr_t;

  logic        CLK = 1'b0;
  logic        iRstN = 1'b0;
  logic [17:0] iData = '0;
  logic        iValid = 1'b0;
  logic        oReady;
  logic [9:0]  oSigmaWriteAddress;
  logic [17:0] oSigmaWriteData;
  logic        oSigmaWE;
  logic [8:0]  oMuWriteAddress;
  logic [17:0] oMuWriteData;
  logic        oMuWE;
  logic        oSwitch;
  logic        oStart;
  logic [26:0] iCoreAcc = '0;
  logic        iCoreDone = 1'b0;
  logic [26:0] oResult;
  logic        oResultValid;
  logic        iResultReady = 1'b0;
  logic [23:0] oChecksum;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  // Reference model state
  wr_t         expQ[$];
  int          mIdx = 0;
  logic [23:0] mSum = '0;
  logic [23:0] batchSum = '0;

  // Event trackers filled by the monitor
  longint lastMuWeCyc = -10;
  longint swToggleCyc = -10;
  longint startCyc = -10;
  int     swToggles = 0;
  int     starts = 0;
  logic   swPrev = 1'b0;
  logic   startPrev = 1'b0;
  wr_t    mon;
  int     obsAddr;
  logic [17:0] obsData;

  mc_table_loader dut (
    .CLK                (CLK),
    .iRstN              (iRstN),
    .iData              (iData),
    .iValid             (iValid),
    .oReady             (oReady),
    .oSigmaWriteAddress (oSigmaWriteAddress),
    .oSigmaWriteData    (oSigmaWriteData),
    .oSigmaWE           (oSigmaWE),
    .oMuWriteAddress    (oMuWriteAddress),
    .oMuWriteData       (oMuWriteData),
    .oMuWE              (oMuWE),
    .oSwitch            (oSwitch),
    .oStart             (oStart),
    .iCoreAcc           (iCoreAcc),
    .iCoreDone          (iCoreDone),
    .oResult            (oResult),
    .oResultValid       (oResultValid),
    .iResultReady       (iResultReady),
    .oChecksum          (oChecksum)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard on table writes plus switch/start event tracking.
  always @(negedge CLK) begin
    if (oSigmaWE || oMuWE) begin
      checks++;
      if (oSigmaWE && oMuWE) begin
        errors++;
        $display("FAIL both_we: sigma and mu WE together at cycle %0d", cyc);
      end else if (expQ.size() == 0) begin
        errors++;
        $display("FAIL spurious_write: write with nothing accepted at cycle %0d", cyc);
      end else begin
        mon     = expQ.pop_front();
        obsAddr = oSigmaWE ? int'(oSigmaWriteAddress) : int'(oMuWriteAddress);
        obsData = oSigmaWE ? oSigmaWriteData : oMuWriteData;
        if (mon.isSigma !== oSigmaWE || mon.addr != obsAddr || mon.data !== obsData
            || mon.stamp != cyc) begin
          errors++;
          $display("FAIL table_write: got sigma=%0b addr=%0d data=%h cyc=%0d, want sigma=%0b addr=%0d data=%h cyc=%0d",
                   oSigmaWE, obsAddr, obsData, cyc, mon.isSigma, mon.addr, mon.data, mon.stamp);
        end
      end
    end
    if (expQ.size() > 0 && expQ[0].stamp < cyc) begin
      checks++;
      errors++;
      mon = expQ.pop_front();
      $display("FAIL missing_write: addr %0d due at cycle %0d not seen", mon.addr, mon.stamp);
    end
    if (oMuWE && oMuWriteAddress == 9'd511) lastMuWeCyc = cyc;
    if (oSwitch !== swPrev) begin
      swToggleCyc = cyc;
      swToggles++;
    end
    swPrev = oSwitch;
    if (oStart) begin
      if (startPrev) begin
        checks++;
        errors++;
        $display("FAIL start_width: oStart high for more than one cycle at %0d", cyc);
      end else begin
        startCyc = cyc;
        starts++;
      end
    end
    startPrev = oStart;
  end

  function automatic logic [17:0] word_for(input int idx, input int mode);
    case (mode)
      0:       return (idx < nSigma) ? 18'(idx) : 18'(32'h20000 + idx - nSigma);
      1:       return 18'($urandom);
      default: return 18'd1;
    endcase
  endfunction

  function automatic logic [23:0] exp_checksum();
`ifdef MC_TABLE_LOADER_CHECKSUM_EN
    return batchSum;
`else
    return 24'd0;
`endif
  endfunction

  // Drive n words; gapMode 0 = always valid, 1 = alternate 1,0,..., 2 = random.
  // Called and returns at posedge+1.
  task automatic send_words(input int n, input int mode, input int gapMode);
    int          sent = 0;
    int          stall = 0;
    bit          have = 0;
    bit          phase = 0;
    logic [17:0] w = '0;
    wr_t         e;
    while (sent < n) begin
      if (!have) begin
        w    = word_for(mIdx, mode);
        have = 1;
      end
      if (gapMode == 1) begin
        iValid = !phase;
        phase  = !phase;
      end else if (gapMode == 2) begin
        iValid = ($urandom_range(0, 2) != 0);
      end else begin
        iValid = 1'b1;
      end
      iData = iValid ? w : 18'($urandom);
      @(negedge CLK);
      if (iValid) begin
        if (oReady) begin
          e.isSigma = (mIdx < nSigma);
          e.addr    = e.isSigma ? mIdx : mIdx - nSigma;
          e.data    = w;
          e.stamp   = cyc + 1;
          expQ.push_back(e);
          mSum = mSum + 24'(w);
          mIdx++;
          if (mIdx == nBatch) begin
            mIdx     = 0;
            batchSum = mSum;
            mSum     = '0;
          end
          sent++;
          have  = 0;
          stall = 0;
        end else begin
          stall++;
          if (stall > 50) begin
            checks++;
            errors++;
            $display("FAIL ready_stall: oReady low for 50 cycles while loading, got %0b want 1", oReady);
            sent = n;
          end
        end
      end
      @(posedge CLK);
      #1;
    end
    iValid = 1'b0;
  endtask

  task automatic wait_start(input int baseStarts, input string tag, output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (starts > baseStarts) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: no oStart within 60 cycles (starts=%0d want >%0d)", tag, starts, baseStarts);
    end
  endtask

  task automatic check_handover(input string tag, input bit immediate, input int t0,
                                input logic expSwitch);
    if (immediate) begin
      checks++;
      if (swToggleCyc != lastMuWeCyc + 1) begin
        errors++;
        $display("FAIL %s_switch_time: toggle at %0d want %0d", tag, swToggleCyc, lastMuWeCyc + 1);
      end
    end
    checks++;
    if (startCyc != swToggleCyc + 1) begin
      errors++;
      $display("FAIL %s_start_time: start at %0d want %0d", tag, startCyc, swToggleCyc + 1);
    end
    checks++;
    if (swToggles != t0 + 1 || oSwitch !== expSwitch) begin
      errors++;
      $display("FAIL %s_switch: toggles=%0d switch=%0b want toggles=%0d switch=%0b",
               tag, swToggles, oSwitch, t0 + 1, expSwitch);
    end
    checks++;
    if (oChecksum !== exp_checksum()) begin
      errors++;
      $display("FAIL %s_checksum: got %h want %h", tag, oChecksum, exp_checksum());
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (oReady !== 1'b1 || oSwitch !== 1'b0 || oStart !== 1'b0 || oSigmaWE !== 1'b0
        || oMuWE !== 1'b0 || oSigmaWriteAddress !== '0 || oSigmaWriteData !== '0
        || oMuWriteAddress !== '0 || oMuWriteData !== '0 || oResult !== '0
        || oResultValid !== 1'b0 || oChecksum !== '0) begin
      errors++;
      $display("FAIL %s: rdy=%0b sw=%0b st=%0b swe=%0b mwe=%0b sa=%h sd=%h ma=%h md=%h res=%h rv=%0b ck=%h want rdy=1 rest 0",
               tag, oReady, oSwitch, oStart, oSigmaWE, oMuWE, oSigmaWriteAddress,
               oSigmaWriteData, oMuWriteAddress, oMuWriteData, oResult, oResultValid, oChecksum);
    end
  endtask

  task automatic capture_result(input logic [26:0] acc, input string tag);
    iCoreAcc  = acc;
    iCoreDone = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (oResultValid !== 1'b1 || oResult !== acc) begin
      errors++;
      $display("FAIL %s_capture: valid=%0b result=%h want valid=1 result=%h", tag, oResultValid, oResult, acc);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drain_result(input string tag);
    iResultReady = 1'b1;
    iCoreDone    = 1'b0;
    @(posedge CLK);
    #1;
    iResultReady = 1'b0;
    @(negedge CLK);
    checks++;
    if (oResultValid !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: valid=%0b want 0", tag, oResultValid);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #12;
    check_idle_outputs("reset_state");
    @(posedge CLK);
    #1;
    iRstN = 1'b1;
    @(negedge CLK);
    check_idle_outputs("after_release");
    @(posedge CLK);
    #1;
  endtask

  task automatic test_ignored_done();
    iCoreAcc  = 27'h5a5a5;
    iCoreDone = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    iCoreDone = 1'b0;
    @(negedge CLK);
    checks++;
    if (oResultValid !== 1'b0 || oResult !== '0) begin
      errors++;
      $display("FAIL idle_done: valid=%0b result=%h want 0/0", oResultValid, oResult);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_batch_basic();
    int s0 = starts;
    int t0 = swToggles;
    bit ok;
    send_words(nBatch, 0, 0);
    wait_start(s0, "basic_start", ok);
    if (ok) check_handover("basic", 1, t0, 1'b1);
    @(negedge CLK);
    checks++;
    if (oStart !== 1'b0 || oReady !== 1'b1) begin
      errors++;
      $display("FAIL basic_after_start: start=%0b ready=%0b want 0/1", oStart, oReady);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_batch_busy();
    int s0 = starts;
    int t0 = swToggles;
    bit ok;
    send_words(nBatch, 1, 2);
    repeat (20) @(negedge CLK);
    checks++;
    if (swToggles != t0 || starts != s0 || oReady !== 1'b0) begin
      errors++;
      $display("FAIL busy_hold: toggles=%0d starts=%0d ready=%0b want %0d/%0d/0",
               swToggles, starts, oReady, t0, s0);
    end
    @(posedge CLK);
    #1;
    capture_result(27'h1234, "busy");
    repeat (10) @(negedge CLK);
    checks++;
    if (swToggles != t0 || oResultValid !== 1'b1 || oResult !== 27'h1234) begin
      errors++;
      $display("FAIL busy_slot_hold: toggles=%0d valid=%0b result=%h want %0d/1/1234",
               swToggles, oResultValid, oResult, t0);
    end
    @(posedge CLK);
    #1;
    drain_result("busy");
    wait_start(s0, "busy_start", ok);
    if (ok) check_handover("busy", 0, t0, 1'b0);
    @(posedge CLK);
    #1;
  endtask

  task automatic test_back_to_back();
    int s0 = starts;
    int t0 = swToggles;
    bit ok;
    logic [26:0] acc;
    send_words(400, 2, 0);
    acc = 27'($urandom);
    capture_result(acc, "b2b");
    drain_result("b2b");
    send_words(nBatch - 400, 2, 0);
    wait_start(s0, "b2b_start", ok);
    if (ok) begin
      check_handover("b2b", 1, t0, 1'b1);
`ifdef MC_TABLE_LOADER_CHECKSUM_EN
      checks++;
      if (oChecksum !== 24'h000600) begin
        errors++;
        $display("FAIL ones_checksum: got %h want 000600", oChecksum);
      end
`endif
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset_mid();
    int s0;
    int t0;
    bit ok;
    send_words(300, 1, 1);
    @(negedge CLK);
    #2;
    iRstN = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    expQ.delete();
    mIdx = 0;
    mSum = '0;
    repeat (2) @(posedge CLK);
    #1;
    iRstN = 1'b1;
    s0 = starts;
    t0 = swToggles;
    send_words(1, 1, 0);
    @(negedge CLK);
    checks++;
    if (oSigmaWE !== 1'b1 || oSigmaWriteAddress !== 10'd0) begin
      errors++;
      $display("FAIL reset_restart: we=%0b addr=%0d want 1/0", oSigmaWE, oSigmaWriteAddress);
    end
    @(posedge CLK);
    #1;
    send_words(nBatch - 1, 1, 2);
    wait_start(s0, "post_reset_start", ok);
    if (ok) check_handover("post_reset", 1, t0, 1'b1);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    test_reset();
    test_ignored_done();
    test_batch_basic();
    test_batch_busy();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
